// File: rtl/fx_slave.sv
`default_nettype none
// ============================================================================
// fx_slave : fx bus responder with ID/CTRL/STAT/FCNT registers and a byte
//            write FIFO drained to a ready/valid stream.
// Rev 1.0
// ============================================================================
module fx_slave #(
  parameter logic [21:0] BASE  = 22'h000100,
  parameter logic [7:0]  ID    = 8'hA5,
  parameter int          DEPTH = 16,
  parameter int          AW    = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        fx_wr,
  input  logic [21:0] fx_waddr,
  input  logic [7:0]  fx_data,
  input  logic        fx_rd,
  input  logic [21:0] fx_raddr,
  output logic [7:0]  fx_q,
  output logic [7:0]  ctrl,
  output logic [7:0]  st_data,
  output logic        st_vld,
  input  logic        st_rdy
);

  localparam logic [7:0]    OFF_ID   = 8'h00;
  localparam logic [7:0]    OFF_CTRL = 8'h01;
  localparam logic [7:0]    OFF_STAT = 8'h02;
  localparam logic [7:0]    OFF_FCNT = 8'h03;
  localparam logic [7:0]    OFF_FIFO = 8'h04;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    rdata_q, rdata_d;

  logic       wr_hit, rd_hit;
  logic [7:0] woff, roff;
  logic       full, empty;
  logic       push, pop, ovf_set;
  logic [7:0] head, fcnt, rd_mux;

  assign wr_hit = fx_wr && (fx_waddr[21:8] == BASE[21:8]);
  assign rd_hit = fx_rd && (fx_raddr[21:8] == BASE[21:8]);
  assign woff   = fx_waddr[7:0];
  assign roff   = fx_raddr[7:0];

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fcnt    = 8'(count_q);

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room.
  assign push    = wr_hit && (woff == OFF_FIFO) && !full;
  assign ovf_set = wr_hit && (woff == OFF_FIFO) && full;
  assign pop     = !empty && st_rdy;

  always_comb begin
    rd_mux = 8'h00;
    case (roff)
      OFF_ID:   rd_mux = ID;
      OFF_CTRL: rd_mux = ctrl_q;
      OFF_STAT: rd_mux = {ovf_q, 5'b00000, full, empty};
      OFF_FCNT: rd_mux = fcnt;
      OFF_FIFO: rd_mux = head;
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new overflow beats the clear-on-read of STAT.
    if (rd_hit && (roff == OFF_STAT)) ovf_d = 1'b0;
    if (ovf_set)                      ovf_d = 1'b1;

    if (wr_hit && (woff == OFF_CTRL)) ctrl_d = fx_data;
    if (rd_hit)                       rdata_d = rd_mux;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ctrl_q   <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= fx_data;
  end

  assign fx_q    = rdata_q;
  assign ctrl    = ctrl_q;
  assign st_data = head;
  assign st_vld  = !empty;

endmodule
`default_nettype wire

// File: tb/tb_fx_slave.sv
`default_nettype none
// ============================================================================
// tb_fx_slave : vector table, directed corner sequences and random traffic
//               checked against a queue-based model of the register window.
// Rev 1.0
// ============================================================================
module tb_fx_slave;

  localparam logic [21:0] BASE = 22'h000100;
  localparam logic [21:0] MISS = 22'h000200;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        fx_wr   = 1'b0;
  logic [21:0] fx_waddr = '0;
  logic [7:0]  fx_data  = '0;
  logic        fx_rd   = 1'b0;
  logic [21:0] fx_raddr = '0;
  logic [7:0]  fx_q, ctrl, st_data;
  logic        st_vld;
  logic        st_rdy  = 1'b0;

  int total = 0;
  int bad   = 0;

  fx_slave dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .fx_wr   (fx_wr),
    .fx_waddr(fx_waddr),
    .fx_data (fx_data),
    .fx_rd   (fx_rd),
    .fx_raddr(fx_raddr),
    .fx_q    (fx_q),
    .ctrl    (ctrl),
    .st_data (st_data),
    .st_vld  (st_vld),
    .st_rdy  (st_rdy)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: the FIFO is just a queue of bytes.
  logic [7:0] mq[$];
  logic [7:0] m_ctrl, m_fxq;
  logic       m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_hit(input logic [21:0] a);
    return a[21:8] == BASE[21:8];
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] off);
    logic [7:0] r;
    case (off)
      8'h00:   r = 8'hA5;
      8'h01:   r = m_ctrl;
      8'h02:   r = {m_ovf, 5'b0, mq.size() == 16, mq.size() == 0};
      8'h03:   r = 8'(mq.size());
      8'h04:   r = (mq.size() != 0) ? mq[0] : 8'h00;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic check_model();
    chk("fx_q", fx_q, m_fxq);
    chk("ctrl", ctrl, m_ctrl);
    chk("st_vld", 8'(st_vld), 8'(mq.size() != 0));
    chk("st_data", st_data, (mq.size() != 0) ? mq[0] : 8'h00);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ctrl = 8'h00;
    m_fxq  = 8'h00;
    m_ovf  = 1'b0;
  endtask

  // One bus cycle: apply inputs, advance the model, clock, compare.
  task automatic drive(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [21:0] ra, input logic rdy);
    logic was_full, was_empty, fifo_wr;
    fx_wr = wr; fx_waddr = wa; fx_data = wd;
    fx_rd = rd; fx_raddr = ra; st_rdy = rdy;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    fifo_wr   = wr && is_hit(wa) && (wa[7:0] == 8'h04);
    if (rd && is_hit(ra)) begin
      m_fxq = m_read(ra[7:0]);
      if (ra[7:0] == 8'h02) m_ovf = 1'b0;
    end
    if (wr && is_hit(wa) && wa[7:0] == 8'h01) m_ctrl = wd;
    if (fifo_wr && was_full) m_ovf = 1'b1;
    if (!was_empty && rdy) void'(mq.pop_front());
    if (fifo_wr && !was_full) mq.push_back(wd);
    @(posedge clk_sys);
    #1;
    check_model();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 8'h00, 1'b0, '0, rdy);
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [7:0] d, input logic rdy);
    drive(1'b1, BASE | 22'(off), d, 1'b0, '0, rdy);
  endtask

  task automatic rd_reg(input logic [7:0] off, input logic rdy);
    drive(1'b0, '0, 8'h00, 1'b1, BASE | 22'(off), rdy);
  endtask

  task automatic do_reset();
    fx_wr = 1'b0; fx_rd = 1'b0; st_rdy = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [21:0] wa;
    logic [7:0]  wd;
    logic        rd;
    logic [21:0] ra;
    logic        rdy;
    logic [7:0]  e_fxq;
    logic [7:0]  e_ctrl;
    logic        e_vld;
    logic [7:0]  e_sdata;
  } vec_t;

  vec_t vt[15];

  initial begin
    vt[0]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000100, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00};
    vt[1]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000101, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vt[2]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000102, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00};
    vt[3]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000103, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vt[4]  = '{1'b1, 22'h000101,   8'h3C, 1'b0, '0,         1'b0, 8'h00, 8'h3C, 1'b0, 8'h00};
    vt[5]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000101, 1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00};
    vt[6]  = '{1'b1, 22'h000201,   8'h77, 1'b0, '0,         1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00};
    vt[7]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000300, 1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 22'h000100,   8'hFF, 1'b1, 22'h000100, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'h00};
    vt[9]  = '{1'b0, '0,           8'h00, 1'b1, 22'h000105, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h00};
    vt[10] = '{1'b1, 22'h000104,   8'h55, 1'b1, 22'h000103, 1'b0, 8'h00, 8'h3C, 1'b1, 8'h55};
    vt[11] = '{1'b0, '0,           8'h00, 1'b1, 22'h000104, 1'b0, 8'h55, 8'h3C, 1'b1, 8'h55};
    vt[12] = '{1'b0, '0,           8'h00, 1'b1, 22'h000103, 1'b0, 8'h01, 8'h3C, 1'b1, 8'h55};
    vt[13] = '{1'b0, '0,           8'h00, 1'b0, '0,         1'b1, 8'h01, 8'h3C, 1'b0, 8'h00};
    vt[14] = '{1'b0, '0,           8'h00, 1'b1, 22'h000102, 1'b0, 8'h01, 8'h3C, 1'b0, 8'h00};

    do_reset();
    chk("rst_fx_q", fx_q, 8'h00);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_st_vld", 8'(st_vld), 8'h00);
    chk("rst_st_data", st_data, 8'h00);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rd, vt[i].ra, vt[i].rdy);
      chk($sformatf("vec%0d_fx_q", i), fx_q, vt[i].e_fxq);
      chk($sformatf("vec%0d_ctrl", i), ctrl, vt[i].e_ctrl);
      chk($sformatf("vec%0d_st_vld", i), 8'(st_vld), 8'(vt[i].e_vld));
      chk($sformatf("vec%0d_st_data", i), st_data, vt[i].e_sdata);
    end

    // Fill to full, then overflow while reading STAT in the same cycle.
    for (int i = 0; i < 16; i++) wr_reg(8'h04, 8'(8'h10 + i), 1'b0);
    drive(1'b1, BASE | 22'h04, 8'h20, 1'b1, BASE | 22'h02, 1'b0);
    chk("stat_pre_ovf", fx_q, 8'h02);
    rd_reg(8'h02, 1'b0);
    chk("stat_ovf", fx_q, 8'h82);
    rd_reg(8'h03, 1'b0);
    chk("fcnt_full", fx_q, 8'h10);
    rd_reg(8'h02, 1'b0);
    chk("stat_ovf_cleared", fx_q, 8'h02);

    for (int i = 0; i < 16; i++) begin
      chk("drain_vld", 8'(st_vld), 8'h01);
      chk("drain_data", st_data, 8'(8'h10 + i));
      idle(1'b1);
    end
    chk("drain_done_vld", 8'(st_vld), 8'h00);
    rd_reg(8'h02, 1'b0);
    chk("stat_empty", fx_q, 8'h01);

    // Push coinciding with a pop at occupancy 3.
    wr_reg(8'h04, 8'hA1, 1'b0);
    wr_reg(8'h04, 8'hA2, 1'b0);
    wr_reg(8'h04, 8'hA3, 1'b0);
    wr_reg(8'h04, 8'hA4, 1'b1);
    rd_reg(8'h03, 1'b0);
    chk("fcnt_push_pop", fx_q, 8'h03);
    for (int i = 0; i < 3; i++) begin
      chk("order_data", st_data, 8'(8'hA2 + i));
      idle(1'b1);
    end
    chk("order_empty", 8'(st_vld), 8'h00);

    // Continuous streaming across pointer wraps.
    for (int i = 0; i < 40; i++) wr_reg(8'h04, 8'(i * 7 + 3), 1'b1);
    idle(1'b1);
    chk("stream_empty", 8'(st_vld), 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [21:0] wa, ra;
      int sel;
      sel = $urandom_range(0, 9);
      wa  = (sel == 9) ? (MISS | 22'($urandom_range(0, 5))) :
            (BASE | 22'((sel < 5) ? 4 : $urandom_range(0, 6)));
      sel = $urandom_range(0, 9);
      ra  = (sel == 9) ? (MISS | 22'($urandom_range(0, 5))) :
            (BASE | 22'($urandom_range(0, 6)));
      drive(1'($urandom_range(0, 1)), wa, 8'($urandom),
            1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 5; i++) wr_reg(8'h04, 8'(8'hC0 + i), 1'b0);
    chk("pre_rst_vld", 8'(st_vld), 8'h01);
    fx_wr = 1'b1; fx_waddr = BASE | 22'h04; fx_data = 8'hEE; st_rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 8'(st_vld), 8'h00);
    chk("async_rst_data", st_data, 8'h00);
    model_reset();
    fx_wr = 1'b0; st_rdy = 1'b0;
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    rd_reg(8'h03, 1'b0);
    chk("fcnt_after_rst", fx_q, 8'h00);
    chk("vld_after_rst", 8'(st_vld), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fx_slave.md
# fx_slave

Responder end of the fx bus: decodes single-cycle write and read strobes from the fx bus master and serves a small register window at a configurable base address. The window holds an ID register, a control register, a status register and a write FIFO whose contents are drained to a downstream byte stream. It sits beside the UART command path so host commands can configure logic and stream bytes into it.

## Interface
- BASE, 22'h000100, window base; only bits [21:8] are compared, bits [7:0] are the local offset
- ID, 8'hA5, value returned at offset 0x00
- DEPTH, 16, FIFO depth in bytes; power of two, 2..128
- AW, 4, log2(DEPTH)

- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- fx_wr  in  1  write strobe, one cycle per write
- fx_waddr  in  22  write address, valid with fx_wr
- fx_data  in  8  write data, valid with fx_wr
- fx_rd  in  1  read strobe, one cycle per read
- fx_raddr  in  22  read address, valid with fx_rd
- fx_q  out  8  read data, registered
- ctrl  out  8  CTRL register contents
- st_data  out  8  FIFO head byte
- st_vld  out  1  FIFO not empty
- st_rdy  in  1  downstream accepts st_data when st_vld & st_rdy

## Operation
- Hit: addr[21:8] == BASE[21:8]; miss accesses are ignored entirely (no state change, fx_q holds).
- Map (offset = addr[7:0]):
  - 0x00 ID: RO, returns ID; writes ignored.
  - 0x01 CTRL: RW, drives ctrl.
  - 0x02 STAT: RO, {ovf, 5'b0, full, empty}; ovf is sticky; a read clears ovf.
  - 0x03 FCNT: RO, current FIFO occupancy 0..DEPTH, zero-extended to 8 bits.
  - 0x04 FIFO: write pushes fx_data; read returns head byte without popping (0x00 when empty).
  - Other offsets: reads return 0x00, writes ignored.
- FIFO: DEPTH x 8 storage, AW-bit wr/rd pointers wrapping modulo DEPTH, (AW+1)-bit count.
  - Push on write hit to 0x04 when not full; when full the byte is dropped and ovf sets.
  - Pop when st_vld & st_rdy.
  - Push and pop in the same cycle: both happen, count unchanged. When full, a pop in the same cycle does NOT make room for the push; the push is dropped and ovf sets.
  - full = (count == DEPTH), empty = (count == 0).
- fx_wr and fx_rd in the same cycle are both serviced; the read sees pre-write state.
- STAT read in the same cycle as a new overflow: the set wins, so ovf = 1 afterwards.

## Timing
- Reset values: fx_q = 0x00, ctrl = 0x00, st_vld = 0, st_data = 0x00, count = 0, pointers = 0, ovf = 0.
- Write: state updates at the clock edge that samples fx_wr; ctrl changes one cycle after the strobe.
- Read: fx_q is valid the cycle after fx_rd (1-cycle latency) and holds until the next hit read.
- Reads reflect register state before that edge's updates.
- Stream: st_vld rises one cycle after the first push into an empty FIFO. st_data is the head entry and is stable while st_vld & !st_rdy. Back-to-back pops run at one byte per cycle.
- Reset asserted mid-operation clears the FIFO and all registers immediately; in-flight strobes are lost.

## Test plan
- Reset, then read 0x00, 0x01, 0x02, 0x03 -> fx_q = 0xA5, 0x00, 0x01, 0x00, each one cycle after fx_rd.
- Write 0x3C to BASE+0x01, read back -> ctrl = 0x3C from the next cycle; fx_q = 0x3C. Write to 22'h000201 -> ctrl unchanged.
- Hold st_rdy = 0. Push 0x10..0x1F (16 bytes), then push 0x20 -> STAT reads 0x82, FCNT reads 0x10. A second STAT read returns 0x02.
- Raise st_rdy -> st_data sequence 0x10..0x1F on 16 consecutive cycles, then st_vld = 0; STAT = 0x01; 0x20 is never emitted.
- With FIFO holding 3 bytes, push in the same cycle as a pop -> FCNT stays 3 and byte order is preserved. Run continuous push/pop for 40 bytes -> pointer wrap is correct with no loss.
- Same-cycle write 0x55 to 0x04 and read of FCNT on an empty FIFO -> fx_q = 0x00 and st_vld = 1 the next cycle. Assert rst_n low mid-stream -> st_vld = 0 and FCNT = 0 after release.
